rx_agc_200k: RTL and testbench
==============================

Name: rx_agc_200k

Overview:
- Digital AGC on the decimated 200 kS/s I/Q stream. Sits directly downstream of the 10k decimation chain's final RC FIR, round and saturate output, and feeds the demodulator.
- Measures the post-gain magnitude over fixed windows and steps a shared I/Q gain toward a programmable target.
- Two loop states: coarse acquisition and fine tracking, plus a manual-gain bypass.

Parameters:
- DW, 16, I/Q sample width, signed two's complement.
- GW, 12, gain width; unsigned Q4.8, 256 = unity.
- WIN_LOG2, 6, measurement window = 2^WIN_LOG2 output samples.
- STEP_ACQ, 16, gain step in ACQ.
- STEP_TRK, 1, gain step in TRACK.
- LOCK_CNT, 4, consecutive in-band windows required to lock.
- GAIN_MIN, 16, lower gain clamp.
- GAIN_MAX, 4095, upper gain clamp.

Ports:
- clk_200m  in  1  system clock.
- cfg_rst  in  1  asynchronous active-high reset.
- din_valid  in  1  one-cycle strobe per 200k sample.
- din_i  in  DW  input I sample.
- din_q  in  DW  input Q sample.
- agc_en  in  1  1 = closed loop; 0 = manual gain.
- agc_target  in  17  target mean of |I|+|Q|.
- agc_hyst  in  16  half-width of the in-band region.
- gain_manual  in  GW  manual gain; also the loop start value.
- dout_valid  out  1  output strobe.
- dout_i  out  DW  gained I sample.
- dout_q  out  DW  gained Q sample.
- gain_out  out  GW  gain currently applied.
- agc_lock  out  1  1 while in TRACK.

Behaviour:
- Reset (cfg_rst, asynchronous, active-high; clock clk_200m): dout_valid=0, dout_i=dout_q=0, gain_out=256, agc_lock=0, state=IDLE, accumulator=0, window counter=0, lock counter=0.
- Datapath, latency exactly 3 cycles, din_valid to dout_valid:
  - S1: register din_i and din_q.
  - S2: signed DW x unsigned GW product, DW+GW+1 bits.
  - S3: add 128, arithmetic shift right by 8, saturate to DW (+32767 / -32768).
  - Gain is sampled at S2.
- Magnitude is |dout_i|+|dout_q|, 17 bits unsigned. |-32768| = 32768.
  - It is accumulated on each dout_valid into a DW+1+WIN_LOG2 bit accumulator.
- Window end is the 2^WIN_LOG2-th dout_valid. On that cycle:
  - mean = acc >> WIN_LOG2.
  - Accumulator and window counter restart at 0.
  - Gain update, if any, becomes visible on gain_out the next cycle.
- In-band condition: agc_target-agc_hyst <= mean <= agc_target+agc_hyst, inclusive.
  - Bounds are computed in 18-bit signed; a lower bound below 0 is treated as 0.
- State machine:
  - IDLE (agc_en=0): gain_out=gain_manual every cycle; accumulator and counters held at 0; agc_lock=0.
  - IDLE -> ACQ on agc_en=1: gain starts from gain_manual; fresh window.
  - ACQ: at window end, mean above band -> gain -= STEP_ACQ; mean below band -> gain += STEP_ACQ; in band -> gain held and lock counter +1. Out of band clears the lock counter.
  - ACQ -> TRACK when the lock counter reaches LOCK_CNT; agc_lock=1 from the next cycle.
  - TRACK: at window end, out of band -> gain steps by STEP_TRK in the correcting direction. Two consecutive out-of-band windows -> ACQ, agc_lock=0, lock counter cleared.
  - ANY -> IDLE when agc_en=0: takes effect the next cycle; any partial window is discarded.
- Gain clamp: the result of every step is clamped to [GAIN_MIN, GAIN_MAX]. No wrap-around.
- Simultaneous events:
  - agc_en falling on a window-end cycle: IDLE wins and no update is applied.
  - din_valid during IDLE: still processed using gain_manual.
- din_valid closer than 3 cycles apart: pipeline accepts back-to-back samples with no stall and no backpressure.
- Reset mid-window: everything returns to its reset values; in-flight samples are dropped and no dout_valid is produced.

Decomposition:
- Shared package rx_dsp_pkg holds:
  - Q4.8 unity constant (256).
  - Gain clamp limits.
  - AGC state encoding (IDLE, ACQ, TRACK).
  - The 17-bit magnitude width.
- One sub-module, agc_gain_mult: S1-S3 multiply/round/saturate for a single rail, instantiated twice (I and Q).
- Loop FSM, accumulator and clamp stay in rx_agc_200k.

Test Plan:
1. Unity passthrough:
   - Stimulus: agc_en=0, gain_manual=256; inputs (1000,-1000), (32767,-32768).
   - Response: identical outputs; dout_valid exactly 3 cycles after each din_valid; gain_out=256.
2. Saturation and rounding:
   - Stimulus: agc_en=0, gain_manual=512; inputs I=20000, Q=-20000, then I=3, Q=-3 with gain_manual=384.
   - Response: 32767/-32768, then 5/-4 (4.5 rounds up, -4.5 rounds to -4).
3. Acquisition and lock:
   - Setup: agc_en=1; gain_manual=256, agc_target=4096, agc_hyst=256.
   - Stimulus: constant I=1024, Q=0, din_valid every 1000 cycles.
   - Response: gain rises +16 per window to 960 after 44 windows; agc_lock rises after window 48; gain held at 960.
4. Track loss:
   - Stimulus: from the locked state of test 3, drop input to I=256.
   - Response: the next window steps gain to 961, the following window to 962, then ACQ with agc_lock=0; stepping resumes in +16 increments.
5. Clamp and control:
   - Stimulus: agc_en=1, zero input for 300 windows.
   - Response: gain stops at 4095.
   - Stimulus: then agc_en=0.
   - Response: gain_out=gain_manual the next cycle; agc_lock=0.
6. Reset mid-operation:
   - Stimulus: assert cfg_rst 2 cycles after a din_valid in TRACK.
   - Response: no dout_valid emitted; gain_out=256 and agc_lock=0 immediately.

Source files
------------

// File: rtl/rx_dsp_pkg.sv
// Constants and encodings shared by the decimated-rate receive DSP blocks.
package rx_dsp_pkg;

    localparam int GAIN_FRAC      = 8;
    localparam int GAIN_UNITY     = 256;
    localparam int GAIN_CLAMP_MIN = 16;
    localparam int GAIN_CLAMP_MAX = 4095;
    localparam int MAG_W          = 17;

    typedef enum logic [1:0] {
        AGC_IDLE  = 2'd0,
        AGC_ACQ   = 2'd1,
        AGC_TRACK = 2'd2
    } agc_state_t;

endpackage

// File: rtl/agc_gain_mult.sv
// One rail of the AGC gain stage: register, multiply by Q4.8 gain, round half up, saturate.
module agc_gain_mult
    import rx_dsp_pkg::*;
#(
    parameter int DW = 16,
    parameter int GW = 12
) (
    input  logic                 clk_200m,
    input  logic                 cfg_rst,
    input  logic                 s1_en,
    input  logic                 s2_en,
    input  logic                 s3_en,
    input  logic signed [DW-1:0] din,
    input  logic        [GW-1:0] gain,
    output logic signed [DW-1:0] dout
);

    localparam int PW = DW + GW + 1;
    localparam int RW = PW - GAIN_FRAC;
    localparam logic signed [RW-1:0] SAT_HI   = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_LO   = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] RND_HALF = PW'(1 << (GAIN_FRAC - 1));

    logic signed [DW-1:0] s1_q;
    logic signed [PW-1:0] s2_prod;
    logic signed [PW-1:0] rnd_sum;
    logic signed [RW-1:0] rnd_shr;
    logic signed [DW-1:0] sat_val;

    // Floor shift after adding one half gives round-half-up for both signs.
    assign rnd_sum = s2_prod + RND_HALF;
    assign rnd_shr = RW'(rnd_sum >>> GAIN_FRAC);

    always_comb begin
        if (rnd_shr > SAT_HI) begin
            sat_val = SAT_HI[DW-1:0];
        end else if (rnd_shr < SAT_LO) begin
            sat_val = SAT_LO[DW-1:0];
        end else begin
            sat_val = rnd_shr[DW-1:0];
        end
    end

    always_ff @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) begin
            s1_q    <= '0;
            s2_prod <= '0;
            dout    <= '0;
        end else begin
            if (s1_en) s1_q <= din;
            if (s2_en) s2_prod <= PW'(s1_q) * PW'($signed({1'b0, gain}));
            if (s3_en) dout <= sat_val;
        end
    end

endmodule

// File: rtl/rx_agc_200k.sv
// Digital AGC on the 200 kS/s I/Q stream: windowed |I|+|Q| measurement steering a shared gain.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// AGC_IDLE  | manual gain; accumulator and counters held at zero
// AGC_ACQ   | coarse steps of STEP_ACQ; counts consecutive in-band windows
// AGC_TRACK | locked; fine steps of STEP_TRK; two misses in a row drop to ACQ
module rx_agc_200k
    import rx_dsp_pkg::*;
#(
    parameter int DW       = 16,
    parameter int GW       = 12,
    parameter int WIN_LOG2 = 6,
    parameter int STEP_ACQ = 16,
    parameter int STEP_TRK = 1,
    parameter int LOCK_CNT = 4,
    parameter int GAIN_MIN = GAIN_CLAMP_MIN,
    parameter int GAIN_MAX = GAIN_CLAMP_MAX
) (
    input  logic                 clk_200m,
    input  logic                 cfg_rst,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    input  logic                 agc_en,
    input  logic [MAG_W-1:0]     agc_target,
    input  logic [15:0]          agc_hyst,
    input  logic [GW-1:0]        gain_manual,
    output logic                 dout_valid,
    output logic signed [DW-1:0] dout_i,
    output logic signed [DW-1:0] dout_q,
    output logic [GW-1:0]        gain_out,
    output logic                 agc_lock
);

    localparam int AW  = DW + 1 + WIN_LOG2;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int BW  = MAG_W + 1;

    agc_state_t           state, state_nxt;
    logic                 v1, v2;
    logic [AW-1:0]        acc, acc_nxt, acc_sum;
    logic [WIN_LOG2-1:0]  win_cnt, win_nxt;
    logic [LCW-1:0]       lock_cnt, lock_nxt;
    logic                 miss_cnt, miss_nxt;
    logic [GW-1:0]        gain_nxt;
    logic [MAG_W-1:0]     mag, mean;
    logic signed [BW-1:0] band_lo_s;
    logic [BW-1:0]        band_lo, band_hi;
    logic                 win_end, above, below, in_band;
    int                   step_sz;

    function automatic logic [MAG_W-1:0] mag_of(input logic signed [DW-1:0] x);
        logic signed [DW:0] xe;
        xe = {x[DW-1], x};
        if (xe < 0) xe = -xe;
        return MAG_W'(xe);
    endfunction

    function automatic logic [GW-1:0] clamp_gain(input int g);
        if (g < GAIN_MIN) return GW'(GAIN_MIN);
        else if (g > GAIN_MAX) return GW'(GAIN_MAX);
        else return GW'(g);
    endfunction

    agc_gain_mult #(.DW(DW), .GW(GW)) u_mult_i (
        .clk_200m (clk_200m),
        .cfg_rst  (cfg_rst),
        .s1_en    (din_valid),
        .s2_en    (v1),
        .s3_en    (v2),
        .din      (din_i),
        .gain     (gain_out),
        .dout     (dout_i)
    );

    agc_gain_mult #(.DW(DW), .GW(GW)) u_mult_q (
        .clk_200m (clk_200m),
        .cfg_rst  (cfg_rst),
        .s1_en    (din_valid),
        .s2_en    (v1),
        .s3_en    (v2),
        .din      (din_q),
        .gain     (gain_out),
        .dout     (dout_q)
    );

    assign mag     = mag_of(dout_i) + mag_of(dout_q);
    assign acc_sum = acc + AW'(mag);
    assign win_end = dout_valid && (win_cnt == '1);
    assign mean    = MAG_W'(acc_sum >> WIN_LOG2);

    // A hysteresis wider than the target leaves the lower bound pinned at zero.
    assign band_lo_s = $signed(BW'(agc_target)) - $signed(BW'(agc_hyst));
    assign band_lo   = band_lo_s[BW-1] ? '0 : $unsigned(band_lo_s);
    assign band_hi   = BW'(agc_target) + BW'(agc_hyst);
    assign above     = BW'(mean) > band_hi;
    assign below     = BW'(mean) < band_lo;
    assign in_band   = !above && !below;

    always_ff @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) state <= AGC_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            AGC_IDLE: begin
                if (agc_en) state_nxt = AGC_ACQ;
            end
            AGC_ACQ: begin
                if (!agc_en) state_nxt = AGC_IDLE;
                else if (win_end && in_band && lock_cnt == LCW'(LOCK_CNT - 1)) state_nxt = AGC_TRACK;
            end
            AGC_TRACK: begin
                if (!agc_en) state_nxt = AGC_IDLE;
                else if (win_end && !in_band && miss_cnt) state_nxt = AGC_ACQ;
            end
            default: state_nxt = AGC_IDLE;
        endcase
    end

    always_comb begin
        gain_nxt = gain_out;
        lock_nxt = lock_cnt;
        miss_nxt = miss_cnt;
        acc_nxt  = acc;
        win_nxt  = win_cnt;
        agc_lock = (state == AGC_TRACK);
        step_sz  = (state == AGC_TRACK) ? STEP_TRK : STEP_ACQ;

        // Disable wins over a coincident window end: the loop state is simply dropped.
        if (!agc_en || state == AGC_IDLE) begin
            gain_nxt = gain_manual;
            lock_nxt = '0;
            miss_nxt = 1'b0;
            acc_nxt  = '0;
            win_nxt  = '0;
        end else if (win_end) begin
            acc_nxt = '0;
            win_nxt = '0;
            if (above)      gain_nxt = clamp_gain(int'(gain_out) - step_sz);
            else if (below) gain_nxt = clamp_gain(int'(gain_out) + step_sz);
            if (state == AGC_ACQ) begin
                lock_nxt = in_band ? lock_cnt + LCW'(1) : '0;
                miss_nxt = 1'b0;
            end else if (in_band) begin
                miss_nxt = 1'b0;
            end else if (miss_cnt) begin
                miss_nxt = 1'b0;
                lock_nxt = '0;
            end else begin
                miss_nxt = 1'b1;
            end
        end else if (dout_valid) begin
            acc_nxt = acc_sum;
            win_nxt = win_cnt + WIN_LOG2'(1);
        end
    end

    always_ff @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            dout_valid <= 1'b0;
            gain_out   <= GW'(GAIN_UNITY);
            acc        <= '0;
            win_cnt    <= '0;
            lock_cnt   <= '0;
            miss_cnt   <= 1'b0;
        end else begin
            v1         <= din_valid;
            v2         <= v1;
            dout_valid <= v2;
            gain_out   <= gain_nxt;
            acc        <= acc_nxt;
            win_cnt    <= win_nxt;
            lock_cnt   <= lock_nxt;
            miss_cnt   <= miss_nxt;
        end
    end

endmodule

// File: tb/tb_rx_agc_200k.sv
// Self-checking bench for rx_agc_200k: fixed vectors, random manual traffic and a window-level loop model.
module tb_rx_agc_200k;

    localparam int WIN = 64;

    logic               clk_200m    = 1'b0;
    logic               cfg_rst     = 1'b1;
    logic               din_valid   = 1'b0;
    logic signed [15:0] din_i       = '0;
    logic signed [15:0] din_q       = '0;
    logic               agc_en      = 1'b0;
    logic [16:0]        agc_target  = '0;
    logic [15:0]        agc_hyst    = '0;
    logic [11:0]        gain_manual = 12'd256;
    logic               dout_valid;
    logic signed [15:0] dout_i;
    logic signed [15:0] dout_q;
    logic [11:0]        gain_out;
    logic               agc_lock;

    rx_agc_200k dut (
        .clk_200m    (clk_200m),
        .cfg_rst     (cfg_rst),
        .din_valid   (din_valid),
        .din_i       (din_i),
        .din_q       (din_q),
        .agc_en      (agc_en),
        .agc_target  (agc_target),
        .agc_hyst    (agc_hyst),
        .gain_manual (gain_manual),
        .dout_valid  (dout_valid),
        .dout_i      (dout_i),
        .dout_q      (dout_q),
        .gain_out    (gain_out),
        .agc_lock    (agc_lock)
    );

    always #5 clk_200m = ~clk_200m;

    typedef struct { int i; int q; int g; int ei; int eq; } vec_t;
    typedef struct { int ei; int eq; int cyc; } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_dv  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   m_gain, m_lock, m_miss;
    bit   m_track;

    always @(posedge clk_200m) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    always @(negedge clk_200m) begin
        if (dout_valid === 1'b1) begin
            n_dv++;
            if (exp_q.size() == 0) begin
                check("unexpected_dout_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout_i", int'(dout_i), mon_e.ei);
                check("dout_q", int'(dout_q), mon_e.eq);
                check("latency", cyc - mon_e.cyc, 3);
            end
        end
    end

    function automatic int ref_gain(input int x, input int g);
        real y;
        int  r;
        y = $floor(real'(x) * real'(g) / 256.0 + 0.5);
        r = int'(y);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int clampg(input int g);
        if (g < 16)   return 16;
        if (g > 4095) return 4095;
        return g;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_200m);
        #1;
    endtask

    task automatic send(input int si, input int sq, input int ei, input int eq, input int gap);
        exp_t e;
        din_i     = 16'(si);
        din_q     = 16'(sq);
        din_valid = 1'b1;
        e.ei  = ei;
        e.eq  = eq;
        e.cyc = cyc;
        exp_q.push_back(e);
        tick(1);
        din_valid = 1'b0;
        if (gap > 1) tick(gap - 1);
    endtask

    task automatic start_loop(input int g0);
        gain_manual = 12'(g0);
        tick(2);
        agc_en = 1'b1;
        tick(2);
        m_gain  = g0;
        m_lock  = 0;
        m_miss  = 0;
        m_track = 1'b0;
    endtask

    task automatic stop_loop();
        agc_en = 1'b0;
        tick(2);
    endtask

    // One measurement window against the loop rules, then compare gain and lock.
    task automatic run_window(input int vi, input int vq, input int amp, input int gap);
        int si, sq, ei, eq, sum, mean, lo, hi, dir;
        sum = 0;
        for (int k = 0; k < WIN; k++) begin
            if (amp > 0) begin
                si = int'($urandom_range(2 * amp)) - amp;
                sq = int'($urandom_range(2 * amp)) - amp;
            end else begin
                si = vi;
                sq = vq;
            end
            ei = ref_gain(si, m_gain);
            eq = ref_gain(sq, m_gain);
            sum += iabs(ei) + iabs(eq);
            send(si, sq, ei, eq, gap);
        end
        tick(4);
        mean = sum / WIN;
        lo = int'(agc_target) - int'(agc_hyst);
        if (lo < 0) lo = 0;
        hi = int'(agc_target) + int'(agc_hyst);
        dir = (mean > hi) ? -1 : ((mean < lo) ? 1 : 0);
        m_gain = clampg(m_gain + dir * (m_track ? 1 : 16));
        if (!m_track) begin
            if (dir == 0) m_lock++;
            else          m_lock = 0;
            if (m_lock == 4) begin
                m_track = 1'b1;
                m_miss  = 0;
            end
        end else if (dir == 0) begin
            m_miss = 0;
        end else if (m_miss == 1) begin
            m_track = 1'b0;
            m_miss  = 0;
            m_lock  = 0;
        end else begin
            m_miss = 1;
        end
        check("win_gain", int'(gain_out), m_gain);
        check("win_lock", int'(agc_lock), int'(m_track));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=still_running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   si, sq, dv0, amp;

        tbl[0] = '{1000, -1000, 256, 1000, -1000};
        tbl[1] = '{32767, -32768, 256, 32767, -32768};
        tbl[2] = '{20000, -20000, 512, 32767, -32768};
        tbl[3] = '{3, -3, 384, 5, -4};
        tbl[4] = '{100, -100, 128, 50, -50};
        tbl[5] = '{1, -1, 128, 1, 0};
        tbl[6] = '{-32768, 32767, 4095, -32768, 32767};
        tbl[7] = '{12345, 0, 0, 0, 0};
        tbl[8] = '{255, -255, 257, 256, -256};
        tbl[9] = '{16384, -16385, 512, 32767, -32768};

        tick(3);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_dout_i", int'(dout_i), 0);
        check("rst_dout_q", int'(dout_q), 0);
        check("rst_gain", int'(gain_out), 256);
        check("rst_lock", int'(agc_lock), 0);
        cfg_rst = 1'b0;
        tick(2);

        for (int k = 0; k < 10; k++) begin
            gain_manual = 12'(tbl[k].g);
            tick(2);
            check("manual_gain_out", int'(gain_out), tbl[k].g);
            send(tbl[k].i, tbl[k].q, tbl[k].ei, tbl[k].eq, 4);
        end

        for (int k = 0; k < 150; k++) begin
            if (k % 10 == 0) begin
                gain_manual = 12'($urandom_range(4095));
                tick(2);
            end
            si = int'($urandom_range(65535)) - 32768;
            sq = int'($urandom_range(65535)) - 32768;
            send(si, sq, ref_gain(si, int'(gain_manual)), ref_gain(sq, int'(gain_manual)),
                 1 + int'($urandom_range(2)));
        end
        tick(6);

        agc_target = 17'd4096;
        agc_hyst   = 16'd256;
        start_loop(256);
        for (int w = 1; w <= 48; w++) begin
            run_window(1024, 0, 0, 4);
            if (w == 44) check("acq_gain_960", int'(gain_out), 960);
            if (w == 47) check("lock_before_48", int'(agc_lock), 0);
        end
        check("lock_at_48", int'(agc_lock), 1);
        check("held_960", int'(gain_out), 960);

        run_window(256, 0, 0, 4);
        check("trk_step1", int'(gain_out), 961);
        check("trk_still_locked", int'(agc_lock), 1);
        run_window(256, 0, 0, 4);
        check("trk_step2", int'(gain_out), 962);
        check("trk_lost", int'(agc_lock), 0);
        run_window(256, 0, 0, 4);
        check("reacq_step", int'(gain_out), 978);

        for (int w = 0; w < 200; w++) run_window(0, 0, 0, 1);
        check("clamp_4095", int'(gain_out), 4095);

        agc_target = 17'd100;
        agc_hyst   = 16'd300;
        for (int w = 0; w < 4; w++) run_window(0, 0, 0, 1);
        check("lowbound_lock", int'(agc_lock), 1);
        gain_manual = 12'd300;
        agc_en = 1'b0;
        tick(1);
        check("manual_after_disable", int'(gain_out), 300);
        check("lock_after_disable", int'(agc_lock), 0);
        tick(2);

        agc_target = 17'd0;
        agc_hyst   = 16'd0;
        start_loop(20);
        run_window(10000, 0, 0, 2);
        check("clamp_16", int'(gain_out), 16);
        run_window(10000, 0, 0, 2);
        stop_loop();

        for (int ep = 0; ep < 3; ep++) begin
            agc_target = 17'($urandom_range(20000, 1000));
            agc_hyst   = 16'($urandom_range(2000));
            amp        = int'($urandom_range(20000, 500));
            start_loop(int'($urandom_range(4095, 16)));
            for (int w = 0; w < 12; w++) run_window(0, 0, amp, 1 + int'($urandom_range(3)));
            stop_loop();
        end

        agc_target = 17'd4096;
        agc_hyst   = 16'd256;
        start_loop(960);
        for (int w = 0; w < 4; w++) run_window(1024, 0, 0, 1);
        check("pre_reset_lock", int'(agc_lock), 1);
        send(1024, 0, 3840, 0, 1);
        tick(1);
        exp_q.delete();
        dv0 = n_dv;
        cfg_rst = 1'b1;
        #1;
        check("rst_mid_gain", int'(gain_out), 256);
        check("rst_mid_lock", int'(agc_lock), 0);
        tick(5);
        check("rst_mid_no_dout", n_dv - dv0, 0);
        check("rst_mid_dout_i", int'(dout_i), 0);
        agc_en  = 1'b0;
        cfg_rst = 1'b0;
        tick(3);
        check("post_rst_manual", int'(gain_out), 960);

        check("pending_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
